// File: rtl/wb_ram_burst_if.sv
// Wishbone B4 bus bundle for wb_ram_burst.
// master modport drives address/data/control, slave modport returns ack/err/data.
//   wb_adr_i  byte address          wb_cti_i  cycle type (000/010/111)
//   wb_dat_i  write data            wb_bte_i  burst type (linear/wrap4/8/16)
//   wb_sel_i  byte enables          wb_ack_o  registered acknowledge
//   wb_we_i   write enable          wb_err_o  registered error
//   wb_cyc_i  bus cycle             wb_dat_o  registered read data
//   wb_stb_i  strobe
interface wb_ram_burst_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_BYTES     = 4,
  parameter int BYTE_WIDTH    = 8
);
  localparam int DW = BYTE_WIDTH * NUM_BYTES;

  logic [ADDRESS_WIDTH-1:0] wb_adr_i;
  logic [DW-1:0]            wb_dat_i;
  logic [NUM_BYTES-1:0]     wb_sel_i;
  logic                     wb_we_i;
  logic                     wb_cyc_i;
  logic                     wb_stb_i;
  logic [2:0]               wb_cti_i;
  logic [1:0]               wb_bte_i;
  logic                     wb_ack_o;
  logic                     wb_err_o;
  logic [DW-1:0]            wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/wb_ram_burst.sv
// Wishbone B4 registered-feedback RAM slave with programmable wait states,
// incrementing bursts (linear, wrap4/8/16) and error response for out-of-range
// word indices.
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   wb        slave side of wb_ram_burst_if (address, data, control, ack/err)
//
// state  | meaning
// IDLE   | no transfer in progress, waiting for cyc&stb
// WAIT   | first-beat wait states counting down
// BEAT   | ack/err presented for cur, or beat pending while stb is low
module wb_ram_burst #(
  parameter int                   BYTE_WIDTH    = 8,
  parameter int                   NUM_BYTES     = 4,
  parameter int                   ADDRESS_WIDTH = 32,
  parameter int                   DEPTH         = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] ADDR_MASK = 32'hffff_0000,
  parameter int                   WAIT_STATES   = 0,
  parameter string                MEMFILE       = ""
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_ram_burst_if.slave wb
);
  localparam int DW  = BYTE_WIDTH * NUM_BYTES;
  localparam int LSB = $clog2(NUM_BYTES);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t                   r_state, w_state_nx;
  logic [3:0]               r_cnt, w_cnt_nx;
  logic [ADDRESS_WIDTH-1:0] r_cur, w_cur_nx;
  logic                     r_ack, w_ack_nx;
  logic                     r_err, w_err_nx;
  logic [DW-1:0]            r_dat, w_dat_nx;

  logic                     w_valid;
  logic [ADDRESS_WIDTH-1:0] w_idx;
  logic [ADDRESS_WIDTH-1:0] w_wrap_mask;
  logic [ADDRESS_WIDTH-1:0] w_cur_inc;
  logic [ADDRESS_WIDTH-1:0] w_next;
  logic [ADDRESS_WIDTH-1:0] w_tgt;
  logic                     w_tgt_ok;
  logic                     w_load;
  logic                     w_we;

  assign w_valid = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_idx   = (wb.wb_adr_i & ~ADDR_MASK) >> LSB;

  // Wrap arithmetic works on the word index: only the low log2(N) bits roll over.
  always_comb begin
    w_wrap_mask = '0;
    case (wb.wb_bte_i)
      2'b01:   w_wrap_mask = ADDRESS_WIDTH'(3);
      2'b10:   w_wrap_mask = ADDRESS_WIDTH'(7);
      2'b11:   w_wrap_mask = ADDRESS_WIDTH'(15);
      default: w_wrap_mask = '0;
    endcase
    w_cur_inc = r_cur + ADDRESS_WIDTH'(1);
    if (wb.wb_bte_i == 2'b00) w_next = w_cur_inc;
    else                      w_next = (r_cur & ~w_wrap_mask) | (w_cur_inc & w_wrap_mask);
  end

  // w_load means "present ack/err and data for w_tgt at this edge".
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cur_nx   = r_cur;
    w_ack_nx   = 1'b0;
    w_err_nx   = 1'b0;
    w_dat_nx   = r_dat;
    w_tgt      = r_cur;
    w_load     = 1'b0;
    w_we       = 1'b0;
    w_tgt_ok   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_cur_nx = w_idx;
          w_tgt    = w_idx;
          if (WAIT_STATES == 0) begin
            w_state_nx = S_BEAT;
            w_load     = 1'b1;
          end else begin
            w_state_nx = S_WAIT;
            w_cnt_nx   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!wb.wb_cyc_i) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nx = S_BEAT;
            // If stb dropped during the wait, enter BEAT pending instead.
            w_load     = wb.wb_stb_i;
          end
        end
      end
      S_BEAT: begin
        if (!wb.wb_cyc_i) begin
          w_state_nx = S_IDLE;
        end else if (r_ack || r_err) begin
          if (wb.wb_stb_i) begin
            w_we = r_ack & wb.wb_we_i;
            if (r_ack && wb.wb_cti_i == 3'b010) begin
              w_cur_nx = w_next;
              w_tgt    = w_next;
              w_load   = 1'b1;
            end else begin
              w_state_nx = S_IDLE;
            end
          end
          // stb low: ack/err drop by default and the beat stays pending on cur.
        end else if (wb.wb_stb_i) begin
          w_load = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_load) begin
      w_tgt_ok = (w_tgt < DEPTH_A);
      w_ack_nx = w_tgt_ok;
      w_err_nx = ~w_tgt_ok;
      w_dat_nx = w_tgt_ok ? mem[w_tgt[IW-1:0]] : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cur   <= w_cur_nx;
      r_ack   <= w_ack_nx;
      r_err   <= w_err_nx;
      r_dat   <= w_dat_nx;
    end
  end

  // r_ack implies cur is in range, so the index slice is safe here.
  always_ff @(posedge wb_clk_i) begin
    if (w_we && !wb_rst_i) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wb.wb_sel_i[i])
          mem[r_cur[IW-1:0]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wb.wb_dat_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
endmodule

// File: tb/tb_wb_ram_burst.sv
module tb_wb_ram_burst;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ram_burst_if #(.ADDRESS_WIDTH(32), .NUM_BYTES(4), .BYTE_WIDTH(8)) bus ();
  wb_ram_burst_if #(.ADDRESS_WIDTH(32), .NUM_BYTES(4), .BYTE_WIDTH(8)) bus3 ();

  wb_ram_burst #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus.slave));
  wb_ram_burst #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus3.slave));

  typedef struct {
    bit          err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] adr);
    return (adr & 32'h0000_ffff) >> 2;
  endfunction

  task automatic expect_beat(input int unsigned idx);
    exp_t e;
    e.err     = (idx >= DEPTH);
    e.chk_dat = e.err || known[idx];
    e.dat     = e.err ? 32'h0 : model[idx];
    exp_q.push_back(e);
  endtask

  task automatic apply_write(input int unsigned idx, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model[idx][i*8 +: 8] = d[i*8 +: 8];
    if (s == 4'hf) known[idx] = 1'b1;
  endtask

  task automatic wait_resp(output int lat, output bit to);
    lat = 0;
    to  = 1'b0;
    while (!(bus.wb_ack_o || bus.wb_err_o)) begin
      if (lat >= 20) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] d, input logic [3:0] s);
    int unsigned idx;
    int          lat;
    bit          to;
    idx = idx_of(adr);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = d;    bus.wb_sel_i = s;
    bus.wb_cti_i = 3'b000; bus.wb_bte_i = 2'b00;
    expect_beat(idx);
    wait_resp(lat, to);
    chk("classic_latency", {31'd0, to, 32'(lat)}, 64'd1);
    @(posedge clk);
    if (we && idx < DEPTH) apply_write(idx, d, s);
    #1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    chk("classic_one_cycle", {62'd0, bus.wb_ack_o, bus.wb_err_o}, 64'd0);
  endtask

  // rst_at >= 0 asserts reset between edges while that beat is presented.
  task automatic burst(input bit we, input int unsigned sidx, input logic [31:0] upper,
                       input int nb, input logic [1:0] bte, input int pause_at, input int rst_at);
    int unsigned idx;
    int          n;
    int          lat;
    bit          to;
    bit          e;
    logic [31:0] d;
    logic [3:0]  s;
    idx = sidx;
    n   = 2 << bte;
    for (int k = 0; k < nb; k++) begin
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (k == pause_at && k > 0) begin
        bus.wb_stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pause_drop", {62'd0, bus.wb_ack_o, bus.wb_err_o}, 64'd0);
      end
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
      bus.wb_adr_i = upper | ((idx & 32'h3fff) << 2);
      bus.wb_dat_i = d; bus.wb_sel_i = s;
      bus.wb_cti_i = (k == nb - 1) ? 3'b111 : 3'b010;
      bus.wb_bte_i = bte;
      expect_beat(idx);
      e = (idx >= DEPTH);
      wait_resp(lat, to);
      chk("burst_latency", {31'd0, to, 32'(lat)}, (k == 0 || k == pause_at) ? 64'd1 : 64'd0);
      if (k == rst_at) begin
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("reset_clears", {30'd0, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clk);
      if (we && !e) apply_write(idx, d, s);
      #1;
      if (e || k == nb - 1) begin
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        chk("burst_end", {62'd0, bus.wb_ack_o, bus.wb_err_o}, 64'd0);
        return;
      end
      if (bte == 2'b00) idx = idx + 1;
      else              idx = (idx - (idx % n)) + ((idx + 1) % n);
    end
  endtask

  task automatic ws3_classic(input bit we, input logic [31:0] d, output int lat,
                             output bit saw_err, output logic [31:0] rd);
    bus3.wb_cyc_i = 1'b1; bus3.wb_stb_i = 1'b1; bus3.wb_we_i = we;
    bus3.wb_adr_i = 32'h0; bus3.wb_dat_i = d; bus3.wb_sel_i = 4'hf;
    bus3.wb_cti_i = 3'b000; bus3.wb_bte_i = 2'b00;
    lat = 0;
    saw_err = 1'b0;
    while (!bus3.wb_ack_o) begin
      saw_err |= bus3.wb_err_o;
      if (lat >= 30) break;
      @(posedge clk); #1;
      lat++;
    end
    saw_err |= bus3.wb_err_o;
    rd = bus3.wb_dat_o;
    @(posedge clk); #1;
    bus3.wb_cyc_i = 1'b0; bus3.wb_stb_i = 1'b0; bus3.wb_we_i = 1'b0;
  endtask

  // Scoreboard monitor: a beat is accepted at the next edge when ack|err and cyc&stb.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.wb_ack_o || bus.wb_err_o) && bus.wb_cyc_i && bus.wb_stb_i) begin
      chk("ack_err_exclusive", {63'd0, bus.wb_ack_o & bus.wb_err_o}, 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b with no beat queued", bus.wb_ack_o, bus.wb_err_o);
      end else begin
        e = exp_q.pop_front();
        chk("resp_err", {63'd0, bus.wb_err_o}, {63'd0, e.err});
        if (e.chk_dat) chk("resp_dat", {32'd0, bus.wb_dat_o}, {32'd0, e.dat});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    bit          se;
    logic [31:0] rd;
    logic [31:0] upper;

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0;
    bus.wb_dat_i = 0; bus.wb_sel_i = 0; bus.wb_cti_i = 0; bus.wb_bte_i = 0;
    bus3.wb_cyc_i = 0; bus3.wb_stb_i = 0; bus3.wb_we_i = 0; bus3.wb_adr_i = 0;
    bus3.wb_dat_i = 0; bus3.wb_sel_i = 0; bus3.wb_cti_i = 0; bus3.wb_bte_i = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state0", {30'd0, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o}, 64'd0);
    chk("reset_state3", {30'd0, bus3.wb_ack_o, bus3.wb_err_o, bus3.wb_dat_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Classic write/read at 0x10.
    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hf);
    classic(1'b0, 32'h10, 32'h0, 4'hf);

    // Byte lanes at 0x20.
    classic(1'b1, 32'h20, 32'h11223344, 4'hf);
    classic(1'b1, 32'h20, 32'hAA000000, 4'h8);
    classic(1'b0, 32'h20, 32'h0, 4'hf);
    chk("byte_lane_model", {32'd0, model[8]}, 64'hAA223344);

    // Wait states on the second instance.
    ws3_classic(1'b1, 32'hCAFE0123, lat, se, rd);
    chk("ws3_write_latency", 64'(lat), 64'd4);
    chk("ws3_write_no_err", {63'd0, se}, 64'd0);
    ws3_classic(1'b0, 32'h0, lat, se, rd);
    chk("ws3_read_latency", 64'(lat), 64'd4);
    chk("ws3_read_no_err", {63'd0, se}, 64'd0);
    chk("ws3_read_data", {32'd0, rd}, 64'hCAFE0123);

    // Fill memory so every later read has a known expectation.
    for (int i = 0; i < DEPTH; i++)
      classic(1'b1, 32'(i) << 2, $urandom, 4'hf);

    // Wrap4 read from idx 14 over mem[12..15]=A,B,C,D -> C,D,A,B.
    classic(1'b1, 32'h30, 32'hAAAA_0001, 4'hf);
    classic(1'b1, 32'h34, 32'hBBBB_0002, 4'hf);
    classic(1'b1, 32'h38, 32'hCCCC_0003, 4'hf);
    classic(1'b1, 32'h3C, 32'hDDDD_0004, 4'hf);
    burst(1'b0, 14, 32'h0, 4, 2'b01, -1, -1);

    // Out of range classic write, then neighbours unaffected.
    classic(1'b1, 32'h1000, 32'h55555555, 4'hf);
    classic(1'b0, 32'h0, 32'h0, 4'hf);
    classic(1'b0, 32'hFFC, 32'h0, 4'hf);

    // Linear burst crossing DEPTH: ack, ack, err; then a classic op proves IDLE.
    burst(1'b0, 1022, 32'h0, 4, 2'b00, -1, -1);
    classic(1'b0, 32'h40, 32'h0, 4'hf);

    // Paused wrap8 write burst.
    burst(1'b1, 37, 32'h0, 6, 2'b10, 3, -1);

    // Reset during a write burst, then read back.
    burst(1'b1, 100, 32'h0, 8, 2'b00, -1, 3);
    @(posedge clk); #1;
    for (int i = 100; i < 108; i++)
      classic(1'b0, 32'(i) << 2, 32'h0, 4'hf);

    // Randomised mix.
    for (int t = 0; t < 200; t++) begin
      upper = {16'($urandom_range(0, 65535)), 16'h0};
      if ($urandom_range(0, 2) == 0)
        classic(1'($urandom_range(0, 1)),
                upper | (32'($urandom_range(0, 1039)) << 2) | 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)));
      else
        burst(1'($urandom_range(0, 1)), $urandom_range(0, 1039), upper,
              $urandom_range(1, 10), 2'($urandom_range(0, 3)), $urandom_range(0, 12), -1);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_ram_burst.md
Name: wb_ram_burst

Overview:
- Parametrised Wishbone B4 registered-feedback RAM slave; next generation of the team's single-cycle Wishbone RAM.
- Generalises byte lane count and width, and adds programmable wait states.
- Adds incrementing bursts (CTI/BTE: linear and 4/8/16-beat wrap) and an error response for out-of-range addresses.
- Sits on the core's instruction/data Wishbone ports as simulation and FPGA memory.

Parameters:
- BYTE_WIDTH, 8, bits per byte lane.
- NUM_BYTES, 4, byte lanes per word; power of two, 1..16.
- ADDRESS_WIDTH, 32, width of wb_adr_i (byte address).
- DEPTH, 1024, number of words.
- ADDR_MASK, 32'hffff_0000, address bits cleared before indexing.
- WAIT_STATES, 0, extra idle cycles before the first ack/err of each cycle; range 0..15.
- MEMFILE, "", hex file loaded into memory at time 0 if non-empty.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wb_adr_i  in  ADDRESS_WIDTH  byte address.
- wb_dat_i  in  BYTE_WIDTH*NUM_BYTES  write data.
- wb_sel_i  in  NUM_BYTES  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_ack_o  out  1  registered acknowledge.
- wb_err_o  out  1  registered error.
- wb_dat_o  out  BYTE_WIDTH*NUM_BYTES  registered read data.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM=IDLE, wait counter=0.
- Memory contents are not reset.
- Reset asserted mid-burst: outputs clear immediately; no write occurs at or after the reset edge.
- Word index: idx = (wb_adr_i & ~ADDR_MASK) >> log2(NUM_BYTES). In range iff idx < DEPTH.
- valid = wb_cyc_i & wb_stb_i.
- FSM states: IDLE, WAIT, BEAT.
- IDLE:
  - valid at edge E: latch idx into cur.
  - If WAIT_STATES=0, go to BEAT at E. Otherwise go to WAIT and load the counter.
- WAIT: decrement the counter; when it reaches 0, go to BEAT. Total first-beat latency is 1+WAIT_STATES cycles.
- Entering BEAT, or advancing a beat:
  - cur in range: wb_ack_o<=1, wb_dat_o<=mem[cur].
  - cur out of range: wb_err_o<=1, wb_dat_o<=0.
- ack and err are never high together.
- Acceptance edge = edge with (ack|err) high and valid.
- Write at acceptance edge: if ack & wb_we_i, each lane i with wb_sel_i[i] set is written from wb_dat_i lane i at mem[cur]. Lanes with sel=0 are unchanged. No write ever occurs on err.
- At acceptance edge, cti!=010 or err high: clear ack/err, return to IDLE.
  - A new request can start no earlier than the next edge, so classic back-to-back transfers take 2+WAIT_STATES cycles each.
- At acceptance edge, cti==010 and ack high: compute next address.
  - Linear: next=cur+1.
  - Wrap-N: the low log2(N) bits of cur increment modulo N; upper bits are kept.
  - cur<=next; ack/err recomputed for next as above.
  - Read data for next is loaded at the same edge, giving zero-wait subsequent beats.
- Burst pauses: wb_stb_i low with wb_cyc_i high while in BEAT clears ack/err at the next edge; the FSM holds cur in BEAT-pending.
  - When stb returns, ack/err for cur are reasserted at the following edge; no re-wait.
- wb_cyc_i low at any edge: return to IDLE, clear ack/err, no write.
- Burst beat that crosses DEPTH: err on that beat, then the burst terminates.
- Wrap address arithmetic is done on the word index, never on the byte address.

Test Plan:
- Classic ops, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10. Required: ack one cycle after each stb edge, each ack high exactly one cycle, read data 0xDEADBEEF.
- Byte lanes: write 0x11223344 sel=1111, then 0xAA000000 sel=1000 to 0x20, then read. Required: 0xAA223344.
- Wait states, WAIT_STATES=3: classic read of 0x0. Required: ack rises 4 cycles after stb is first sampled; err never high.
- Wrap4 read burst: start address 0x38 (idx 14), cti=010 for three beats then 111, bte=01, mem[12..15]=A,B,C,D. Required: data C,D,A,B on 4 consecutive ack cycles, then ack low.
- Out of range, DEPTH=1024: classic write to 0x1000 (idx 1024). Required: err high one cycle, ack low, memory unchanged.
  - Linear burst from idx 1022: acks on beats 0-1, err on beat 2, FSM back in IDLE.
- Reset during burst: assert wb_rst_i asynchronously between edges mid-burst. Required: ack drops before the next edge; the remaining beats' writes are absent on readback.
